// File: rtl/i2c_tgt_pkg.sv
// rtl/i2c_tgt_pkg.sv - shared FSM states and bus acknowledge levels for i2c_tgt
package i2c_tgt_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        SKIP
    } state_t;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_tgt_sync.sv
// rtl/i2c_tgt_sync.sv - SCL/SDA synchroniser with SCL edge and START/STOP detection
module i2c_tgt_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_s_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);
    // [1:0] are the synchroniser stages, [2] holds the previous synchronised value
    logic [2:0] scl_q;
    logic [2:0] sda_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            scl_q <= '1;
            sda_q <= '1;
        end else begin
            scl_q <= {scl_q[1:0], scl_i};
            sda_q <= {sda_q[1:0], sda_i};
        end
    end

    assign sda_s_o    = sda_q[1];
    assign scl_rise_o = scl_q[1] & ~scl_q[2];
    assign scl_fall_o = ~scl_q[1] & scl_q[2];
    assign start_o    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    assign stop_o     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/i2c_tgt.sv
// rtl/i2c_tgt.sv - I2C target exposing NREG auto-incrementing 8-bit registers
module i2c_tgt
    import i2c_tgt_pkg::*;
#(
    parameter logic [6:0] TGT_ADDR = 7'h42,
    parameter int         NREG     = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    scl_i,
    input  logic                    sda_i,
    output logic                    sda_o,
    output logic                    sda_dir_o,
    input  logic [$clog2(NREG)-1:0] loc_addr_i,
    output logic [7:0]              loc_rdata_o,
    output logic                    wr_strb_o,
    output logic [$clog2(NREG)-1:0] wr_addr_o,
    output logic [7:0]              wr_data_o
);
    localparam int AW = $clog2(NREG);

    logic sda_s, scl_rise, scl_fall, start, stop;

    i2c_tgt_sync u_sync (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .sda_s_o    (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start),
        .stop_o     (stop)
    );

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          rw_q, rw_d;
    logic          mack_q, mack_d;
    logic          dir_q, dir_d;
    logic          wr_strb_q, wr_strb_d;
    logic [7:0]    regs_q [NREG];
    logic [7:0]    rd_byte;

    assign rd_byte = regs_q[ptr_q];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rw_d      = rw_q;
        mack_d    = mack_q;
        dir_d     = dir_q;
        wr_strb_d = 1'b0;
        if (start) begin
            state_d = ADDR;
            cnt_d   = 4'd0;
            dir_d   = 1'b0;
        end else if (stop) begin
            state_d = IDLE;
            dir_d   = 1'b0;
        end else begin
            case (state_q)
                // Bytes are shifted in on rising SCL and acted on at the following fall
                ADDR, PTR, WDATA: begin
                    if (scl_rise && cnt_q != 4'd8) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                        if (state_q == WDATA && cnt_q == 4'd7) begin
                            wr_strb_d = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = {shift_q[6:0], sda_s};
                        end
                    end
                    if (scl_fall && cnt_q == 4'd8) begin
                        dir_d = ~ACK;
                        if (state_q == ADDR) begin
                            if (shift_q[7:1] == TGT_ADDR) begin
                                state_d = ADDR_ACK;
                                rw_d    = shift_q[0];
                            end else begin
                                state_d = SKIP;
                                dir_d   = 1'b0;
                            end
                        end else if (state_q == PTR) begin
                            state_d = PTR_ACK;
                            ptr_d   = shift_q[AW-1:0];
                        end else begin
                            state_d = WDATA_ACK;
                            ptr_d   = ptr_q + 1'b1;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_d = 4'd0;
                        if (rw_q) begin
                            state_d = RDATA;
                            shift_d = rd_byte;
                            dir_d   = ~rd_byte[7];
                        end else begin
                            state_d = PTR;
                            dir_d   = 1'b0;
                        end
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        state_d = WDATA;
                        cnt_d   = 4'd0;
                        dir_d   = 1'b0;
                    end
                end
                RDATA: begin
                    if (scl_rise && cnt_q != 4'd8) begin
                        cnt_d = cnt_q + 4'd1;
                    end
                    if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            state_d = RDATA_ACK;
                            dir_d   = 1'b0;
                            ptr_d   = ptr_q + 1'b1;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            dir_d   = ~shift_q[6];
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        mack_d = sda_s;
                    end
                    if (scl_fall) begin
                        cnt_d = 4'd0;
                        if (mack_q == NACK) begin
                            state_d = SKIP;
                            dir_d   = 1'b0;
                        end else begin
                            state_d = RDATA;
                            shift_d = rd_byte;
                            dir_d   = ~rd_byte[7];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            shift_q   <= 8'h00;
            ptr_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= 8'h00;
            rw_q      <= 1'b0;
            mack_q    <= NACK;
            dir_q     <= 1'b0;
            wr_strb_q <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rw_q      <= rw_d;
            mack_q    <= mack_d;
            dir_q     <= dir_d;
            wr_strb_q <= wr_strb_d;
            if (wr_strb_d) begin
                regs_q[wr_addr_d] <= wr_data_d;
            end
        end
    end

    assign sda_o       = 1'b0;
    assign sda_dir_o   = dir_q;
    assign loc_rdata_o = regs_q[loc_addr_i];
    assign wr_strb_o   = wr_strb_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;

endmodule

// File: tb/tb_i2c_tgt.sv
// tb/tb_i2c_tgt.sv - self-checking bench for i2c_tgt with a transaction-level register model
module tb_i2c_tgt;
    import i2c_tgt_pkg::*;

    localparam int Q = 6;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       scl      = 1'b1;
    logic       sda_ctl  = 1'b1;
    logic [3:0] loc_addr = 4'd0;
    logic [7:0] loc_rdata, wr_data;
    logic [3:0] wr_addr;
    logic       sda_o, sda_dir, wr_strb;
    wire        sda_bus = sda_ctl & ~sda_dir;

    int         n_vec   = 0;
    int         n_err   = 0;
    int         strobes = 0;
    int         pulls   = 0;
    logic [3:0] last_wa = 4'd0;
    logic [7:0] last_wd = 8'd0;

    logic [7:0] m_regs [16];
    int         m_ptr;

    always #5 clk = ~clk;

    i2c_tgt #(.TGT_ADDR(7'h42), .NREG(16)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .scl_i       (scl),
        .sda_i       (sda_bus),
        .sda_o       (sda_o),
        .sda_dir_o   (sda_dir),
        .loc_addr_i  (loc_addr),
        .loc_rdata_o (loc_rdata),
        .wr_strb_o   (wr_strb),
        .wr_addr_o   (wr_addr),
        .wr_data_o   (wr_data)
    );

    always @(posedge clk) begin
        if (wr_strb) begin
            strobes++;
            last_wa = wr_addr;
            last_wd = wr_data;
        end
        if (sda_dir) pulls++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input int a, input logic [7:0] exp, input string tag);
        loc_addr = a[3:0];
        @(negedge clk);
        chk(tag, {24'd0, loc_rdata}, {24'd0, exp});
    endtask

    task automatic waitq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bit_io(input logic b, output logic s);
        sda_ctl = b;
        waitq();
        scl = 1'b1;
        waitq();
        s = sda_bus;
        waitq();
        scl = 1'b0;
        waitq();
    endtask

    task automatic i2c_start();
        sda_ctl = 1'b1;
        waitq();
        scl = 1'b1;
        waitq();
        sda_ctl = 1'b0;
        waitq();
        scl = 1'b0;
        waitq();
    endtask

    task automatic i2c_stop();
        sda_ctl = 1'b0;
        waitq();
        scl = 1'b1;
        waitq();
        sda_ctl = 1'b1;
        waitq();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack_n);
        logic s;
        for (int i = 7; i >= 0; i--) bit_io(b[i], s);
        bit_io(1'b1, ack_n);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic s;
        d = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, s);
            d[i] = s;
        end
        bit_io(nack, s);
    endtask

    initial begin
        logic       a0, a1, a2, a3, s, acks;
        logic [7:0] d0, d1, p;
        int         n;

        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
        repeat (3) @(negedge clk);
        chk("rst_sda_dir", sda_dir, 0);
        chk("rst_sda_o", sda_o, 0);
        chk("rst_wr_strb", wr_strb, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_state", dut.state_q, IDLE);
        chk("rst_ptr", dut.ptr_q, 0);
        chk_reg(0, 8'h00, "rst_reg0");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Two-byte write at pointer 3
        strobes = 0;
        i2c_start();
        write_byte(8'h84, a0);
        write_byte(8'h03, a1);
        write_byte(8'hA5, a2);
        write_byte(8'h5A, a3);
        i2c_stop();
        m_regs[3] = 8'hA5;
        m_regs[4] = 8'h5A;
        m_ptr = 5;
        chk("t1_acks", {a0, a1, a2, a3}, 0);
        chk_reg(3, 8'hA5, "t1_reg3");
        chk_reg(4, 8'h5A, "t1_reg4");
        chk("t1_strobes", strobes, 2);
        chk("t1_ptr", dut.ptr_q, m_ptr);
        chk("t1_last_wa", last_wa, 4);
        chk("t1_last_wd", last_wd, 8'h5A);

        // Pointer write, repeated START, two-byte read
        i2c_start();
        write_byte(8'h84, a0);
        write_byte(8'h03, a1);
        i2c_start();
        write_byte(8'h85, a2);
        read_byte(d0, 1'b0);
        read_byte(d1, 1'b1);
        i2c_stop();
        chk("t2_acks", {a0, a1, a2}, 0);
        chk("t2_rd0", d0, m_regs[3]);
        chk("t2_rd1", d1, m_regs[4]);
        chk("t2_state", dut.state_q, IDLE);
        chk("t2_ptr", dut.ptr_q, 5);

        // Foreign address must be ignored entirely
        pulls = 0;
        strobes = 0;
        i2c_start();
        write_byte(8'h86, a0);
        write_byte(8'hFF, a1);
        i2c_stop();
        chk("t3_nack", {a0, a1}, 2'b11);
        chk("t3_pulls", pulls, 0);
        chk("t3_strobes", strobes, 0);
        for (int i = 0; i < 16; i++) chk_reg(i, m_regs[i], "t3_regs");

        // Pointer wrap-around from 15 to 0
        i2c_start();
        write_byte(8'h84, a0);
        write_byte(8'h0F, a1);
        write_byte(8'h11, a2);
        write_byte(8'h22, a3);
        i2c_stop();
        m_regs[15] = 8'h11;
        m_regs[0]  = 8'h22;
        chk("t4_acks", {a0, a1, a2, a3}, 0);
        chk_reg(15, 8'h11, "t4_reg15");
        chk_reg(0, 8'h22, "t4_reg0");
        chk("t4_ptr", dut.ptr_q, 1);

        // Partial byte terminated by STOP
        strobes = 0;
        i2c_start();
        write_byte(8'h84, a0);
        write_byte(8'h07, a1);
        bit_io(1'b1, s);
        bit_io(1'b0, s);
        bit_io(1'b1, s);
        bit_io(1'b1, s);
        i2c_stop();
        chk("t5_strobes", strobes, 0);
        chk("t5_ptr", dut.ptr_q, 7);
        chk("t5_state", dut.state_q, IDLE);
        chk_reg(7, m_regs[7], "t5_reg7");

        // Reset while the target drives a 0 read bit (bit 6 of 0xA5)
        i2c_start();
        write_byte(8'h84, a0);
        write_byte(8'h03, a1);
        i2c_start();
        write_byte(8'h85, a2);
        bit_io(1'b1, s);
        chk("t6_bit7", s, 1);
        chk("t6_driving", sda_dir, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_release", sda_dir, 0);
        @(negedge clk);
        chk_reg(3, 8'h00, "t6_rst_reg3");
        chk("t6_rst_state", dut.state_q, IDLE);
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
        scl = 1'b1;
        sda_ctl = 1'b1;
        waitq();
        rst_n = 1'b1;
        waitq();
        pulls = 0;
        strobes = 0;
        write_byte(8'h84, a0);
        write_byte(8'h55, a1);
        chk("t6_nostart_nack", {a0, a1}, 2'b11);
        chk("t6_nostart_pulls", pulls, 0);
        chk("t6_nostart_state", dut.state_q, IDLE);
        i2c_stop();

        // Randomised writes and reads checked against the model
        for (int it = 0; it < 12; it++) begin
            p = 8'($urandom_range(0, 255));
            n = $urandom_range(1, 3);
            i2c_start();
            write_byte(8'h84, a0);
            write_byte(p, a1);
            acks = a0 | a1;
            m_ptr = int'(p) % 16;
            for (int k = 0; k < n; k++) begin
                d0 = 8'($urandom);
                write_byte(d0, a2);
                acks = acks | a2;
                m_regs[m_ptr] = d0;
                m_ptr = (m_ptr + 1) % 16;
            end
            i2c_stop();
            chk("rnd_wr_acks", acks, 0);
            chk("rnd_wr_ptr", dut.ptr_q, m_ptr);

            p = 8'($urandom_range(0, 255));
            n = $urandom_range(1, 3);
            i2c_start();
            write_byte(8'h84, a0);
            write_byte(p, a1);
            i2c_start();
            write_byte(8'h85, a2);
            chk("rnd_rd_acks", {a0, a1, a2}, 0);
            m_ptr = int'(p) % 16;
            for (int k = 0; k < n; k++) begin
                read_byte(d0, (k == n - 1));
                chk("rnd_rd_data", d0, m_regs[m_ptr]);
                m_ptr = (m_ptr + 1) % 16;
            end
            i2c_stop();
            chk("rnd_rd_ptr", dut.ptr_q, m_ptr);
            chk("rnd_rd_state", dut.state_q, IDLE);
        end
        for (int i = 0; i < 16; i++) chk_reg(i, m_regs[i], "rnd_final_regs");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_tgt.md
I2C_TGT -- requirements
Module: i2c_tgt

Interface
REQ-001 The block SHALL have parameter TGT_ADDR, default 7'h42, giving the 7-bit target address it responds to.
REQ-002 The block SHALL have parameter NREG, default 16, giving the number of 8-bit registers; NREG SHALL be a power of two.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single system clock; clk_i SHALL run at least 16x the SCL frequency.
REQ-004 The block SHALL have port rst_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port scl_i, input, 1 bit: the raw I2C SCL line from the pad.
REQ-006 The block SHALL have port sda_i, input, 1 bit: the raw I2C SDA line from the pad.
REQ-007 The block SHALL have port sda_o, output, 1 bit: SDA output value, tied to constant 0 (open-drain).
REQ-008 The block SHALL have port sda_dir_o, output, 1 bit: 1 pulls SDA low, 0 releases SDA.
REQ-009 The block SHALL have port loc_addr_i, input, $clog2(NREG) bits: local read address.
REQ-010 The block SHALL have port loc_rdata_o, output, 8 bits: combinational read of reg[loc_addr_i].
REQ-011 The block SHALL have port wr_strb_o, output, 1 bit: one-cycle pulse per register write from the bus.
REQ-012 The block SHALL have ports wr_addr_o, output, $clog2(NREG) bits, and wr_data_o, output, 8 bits: the register index and data of the current write, valid while wr_strb_o=1.

Function
REQ-013 The block SHALL synchronise scl_i and sda_i through 2 flops each, and SHALL derive all edges and conditions from the synchronised values only.
REQ-014 The block SHALL detect START as SDA falling while SCL is high, and STOP as SDA rising while SCL is high.
REQ-015 The block SHALL sample SDA on each SCL rising edge, MSB first, and SHALL change sda_dir_o only in the clk_i cycle after an SCL falling edge is detected.
REQ-016 The state machine SHALL have states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK and SKIP.
REQ-017 On START (including repeated START) from any state, the FSM SHALL go to ADDR, clear the bit counter and release SDA.
REQ-018 On STOP from any state, the FSM SHALL go to IDLE and release SDA.
REQ-019 If the address matches TGT_ADDR, the FSM SHALL go to ADDR_ACK and drive ACK for one SCL period; then it SHALL go to PTR on a write (R/W=0) or to RDATA on a read (R/W=1).
REQ-020 If the address does not match, the FSM SHALL go to SKIP, keep SDA released (NACK) and stay in SKIP until START or STOP.
REQ-021 The first byte after a write address SHALL be loaded into ptr (low $clog2(NREG) bits) and ACKed; upper bits SHALL be ignored.
REQ-022 Each subsequent write byte SHALL update reg[ptr], pulse wr_strb_o on the cycle the 8th bit is sampled, be ACKed, and then increment ptr modulo NREG.
REQ-023 In RDATA the block SHALL load reg[ptr] into a shift register at SCL fall after ACK, drive each 0 bit low and release for each 1 bit, and increment ptr modulo NREG after the 8th bit.
REQ-024 In RDATA_ACK the block SHALL release SDA and sample the controller ACK; ACK (0) SHALL return the FSM to RDATA, and NACK (1) SHALL send it to SKIP.
REQ-025 ptr SHALL persist across transactions, so that a write-pointer followed by a repeated-START read returns reg[ptr].
REQ-026 A partial byte (fewer than 8 bits) terminated by START or STOP SHALL be discarded, with no write and no ptr change.

Reset
REQ-027 While rst_n_i=0 and immediately upon its assertion, the block SHALL reset: state IDLE, all regs 0x00, ptr 0, sda_dir_o 0, sda_o 0, wr_strb_o 0, wr_addr_o 0, wr_data_o 0, and synchroniser flops to 1 (idle bus).
REQ-028 A reset asserted mid-transfer SHALL release SDA within the same cycle, and the block SHALL ignore bus activity until the next START.

Structure
REQ-029 The state enum and the ACK/NACK constants SHALL live in package i2c_tgt_pkg.
REQ-030 Synchronisation and edge/START/STOP detection SHALL be a sub-module named i2c_tgt_sync.

Verification
REQ-031 Write 0x84, 0x03, 0xA5, 0x5A, STOP -> ACK on all 4 bytes; reg3=0xA5, reg4=0x5A; 2 wr_strb_o pulses; ptr=5.
REQ-032 Write 0x84, 0x03, repeated START, 0x85, read 2 bytes (ACK, then NACK), STOP -> bus returns 0xA5, 0x5A; FSM ends in IDLE.
REQ-033 Send address byte 0x86 (target 0x43) then data 0xFF -> SDA never pulled low; no wr_strb_o; regs unchanged.
REQ-034 Write pointer 0x0F, data 0x11, 0x22 -> reg15=0x11, reg0=0x22; ptr=1.
REQ-035 STOP after 4 data bits -> no wr_strb_o, ptr unchanged, state IDLE; assert rst_n_i while driving a 0 read bit -> sda_dir_o=0 at once.
